// File: rtl/div_sched_pkg.sv
// Shared types for the divide scheduler: op encoding, FSM states, request record
// and small sign helpers used during operand launch and result fix-up.
package Public_Info;

   localparam int unsigned DIV_ITER_DEF = 32;

   typedef enum logic [1:0] {
      DIV  = 2'd0,
      MOD  = 2'd1,
      DIVU = 2'd2,
      MODU = 2'd3
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } sched_state_t;

   typedef struct packed {
      div_op_t     op;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [4:0]  rd;
   } div_req_t;

   function automatic logic is_signed_op(div_op_t op);
      return (op == DIV) || (op == MOD);
   endfunction

   function automatic logic is_rem_op(div_op_t op);
      return (op == MOD) || (op == MODU);
   endfunction

   function automatic logic [31:0] abs32(logic [31:0] v);
      return v[31] ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/div_sched_if.sv
// Request/result bundle between issue logic (master) and the divide scheduler (slave).
interface div_sched_if;
   import Public_Info::*;

   logic        flush;
   logic        ex_stall;
   logic        req_a;
   logic        req_b;
   div_op_t     op_a;
   div_op_t     op_b;
   logic [31:0] src1_a;
   logic [31:0] src2_a;
   logic [31:0] src1_b;
   logic [31:0] src2_b;
   logic [4:0]  rd_a;
   logic [4:0]  rd_b;
   logic        stall_o;
   logic        res_valid;
   logic [31:0] res_data;
   logic [4:0]  res_rd;
   logic        res_lane;

   modport master (
      output flush, ex_stall, req_a, req_b, op_a, op_b,
             src1_a, src2_a, src1_b, src2_b, rd_a, rd_b,
      input  stall_o, res_valid, res_data, res_rd, res_lane
   );

   modport slave (
      input  flush, ex_stall, req_a, req_b, op_a, op_b,
             src1_a, src2_a, src1_b, src2_b, rd_a, rd_b,
      output stall_o, res_valid, res_data, res_rd, res_lane
   );

endinterface

// File: rtl/div_sched_core.sv
// Unsigned restoring shift-subtract divider, one quotient bit per cycle.
// A zero divisor naturally yields quotient all-ones and remainder = dividend.
module div_core
   import Public_Info::*;
#(
   parameter int unsigned DIV_ITER = DIV_ITER_DEF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   localparam int unsigned CW = $clog2(DIV_ITER + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   quo_q, quo_d;
   logic [31:0]   rem_q, rem_d;
   logic [31:0]   dvs_q, dvs_d;
   logic [32:0]   rem_shift;
   logic [32:0]   diff;

   always_comb begin
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      rem_shift = {rem_q, quo_q[31]};
      diff      = rem_shift - {1'b0, dvs_q};
      if (abort) begin
         cnt_d = '0;
      end else if (start) begin
         quo_d = dividend;
         rem_d = '0;
         dvs_d = divisor;
         cnt_d = CW'(DIV_ITER);
      end else if (cnt_q != '0) begin
         if (!diff[32]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
         end else begin
            rem_d = rem_shift[31:0];
            quo_d = {quo_q[30:0], 1'b0};
         end
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
      end
   end

   assign busy      = (cnt_q != '0);
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/div_sched.sv
// Two-lane divide scheduler: arbitrates lane A over B (B parked in a one-entry
// pending slot), owns sign handling around the unsigned core, presents registered results.
module div_sched
   import Public_Info::*;
#(
   parameter int unsigned DIV_ITER = DIV_ITER_DEF
) (
   input  logic        clk,
   input  logic        rstn,
   div_sched_if.slave  bus
);

   sched_state_t state_q, state_d;
   div_req_t     pend_q, pend_d;
   logic         pend_vld_q, pend_vld_d;
   div_op_t      op_q, op_d;
   logic [4:0]   rd_q, rd_d;
   logic         lane_q, lane_d;
   logic         neg_quo_q, neg_quo_d;
   logic         neg_rem_q, neg_rem_d;
   logic [31:0]  res_data_q, res_data_d;
   logic [4:0]   res_rd_q, res_rd_d;
   logic         res_lane_q, res_lane_d;

   div_req_t     req_a_s, req_b_s, launch;
   logic         launch_go, launch_lane;
   logic         core_start, core_abort, core_busy;
   logic [31:0]  core_dvd, core_dvs, core_quo, core_rem;
   logic [31:0]  quo_fix, rem_fix;

   assign req_a_s = '{op: bus.op_a, src1: bus.src1_a, src2: bus.src2_a, rd: bus.rd_a};
   assign req_b_s = '{op: bus.op_b, src1: bus.src1_b, src2: bus.src2_b, rd: bus.rd_b};

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      pend_vld_d  = pend_vld_q;
      op_d        = op_q;
      rd_d        = rd_q;
      lane_d      = lane_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      res_data_d  = res_data_q;
      res_rd_d    = res_rd_q;
      res_lane_d  = res_lane_q;
      launch      = req_a_s;
      launch_go   = 1'b0;
      launch_lane = 1'b0;
      core_start  = 1'b0;
      core_abort  = 1'b0;
      core_dvd    = '0;
      core_dvs    = '0;
      quo_fix     = neg_quo_q ? (32'd0 - core_quo) : core_quo;
      rem_fix     = neg_rem_q ? (32'd0 - core_rem) : core_rem;

      unique case (state_q)
         IDLE: begin
            if (bus.req_a) begin
               launch_go = 1'b1;
               if (bus.req_b) begin
                  pend_d     = req_b_s;
                  pend_vld_d = 1'b1;
               end
            end else if (bus.req_b) begin
               launch      = req_b_s;
               launch_lane = 1'b1;
               launch_go   = 1'b1;
            end
         end
         CALC: begin
            if (!core_busy) begin
               state_d    = DONE;
               res_data_d = is_rem_op(op_q) ? rem_fix : quo_fix;
               res_rd_d   = rd_q;
               res_lane_d = lane_q;
            end
         end
         DONE: begin
            if (!bus.ex_stall) begin
               if (pend_vld_q) begin
                  launch      = pend_q;
                  launch_lane = 1'b1;
                  launch_go   = 1'b1;
                  pend_vld_d  = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A zero divisor keeps the all-ones quotient unsigned-looking, so it is never negated.
      if (launch_go) begin
         state_d    = CALC;
         op_d       = launch.op;
         rd_d       = launch.rd;
         lane_d     = launch_lane;
         neg_quo_d  = is_signed_op(launch.op) && (launch.src1[31] ^ launch.src2[31])
                      && (launch.src2 != '0);
         neg_rem_d  = is_signed_op(launch.op) && launch.src1[31];
         core_start = 1'b1;
         core_dvd   = is_signed_op(launch.op) ? abs32(launch.src1) : launch.src1;
         core_dvs   = is_signed_op(launch.op) ? abs32(launch.src2) : launch.src2;
      end

      if (bus.flush) begin
         state_d    = IDLE;
         pend_vld_d = 1'b0;
         core_start = 1'b0;
         core_abort = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         op_q       <= DIV;
         rd_q       <= '0;
         lane_q     <= 1'b0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         res_data_q <= '0;
         res_rd_q   <= '0;
         res_lane_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         op_q       <= op_d;
         rd_q       <= rd_d;
         lane_q     <= lane_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         res_data_q <= res_data_d;
         res_rd_q   <= res_rd_d;
         res_lane_q <= res_lane_d;
      end
   end

   div_core #(.DIV_ITER(DIV_ITER)) u_core (
      .clk       (clk),
      .rstn      (rstn),
      .start     (core_start),
      .abort     (core_abort),
      .dividend  (core_dvd),
      .divisor   (core_dvs),
      .busy      (core_busy),
      .quotient  (core_quo),
      .remainder (core_rem)
   );

   assign bus.stall_o   = ((state_q == IDLE) && (bus.req_a || bus.req_b))
                        || (state_q == CALC)
                        || ((state_q == DONE) && (bus.ex_stall || pend_vld_q));
   assign bus.res_valid = (state_q == DONE);
   assign bus.res_data  = res_data_q;
   assign bus.res_rd    = res_rd_q;
   assign bus.res_lane  = res_lane_q;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: hand-computed results, latency, arbitration,
// flush, downstream stall and reset abort.
module tb_div_sched;
   import Public_Info::*;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   div_sched_if bus();

   div_sched #(.DIV_ITER(32)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.flush    = 1'b0;
      bus.ex_stall = 1'b0;
      bus.req_a    = 1'b0;
      bus.req_b    = 1'b0;
      bus.op_a     = DIV;
      bus.op_b     = DIV;
      bus.src1_a   = '0;
      bus.src2_a   = '0;
      bus.src1_b   = '0;
      bus.src2_b   = '0;
      bus.rd_a     = '0;
      bus.rd_b     = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until res_valid; stall_ok records stall_o high at every sample before it.
   task automatic wait_valid(input int limit, output int cyc, output bit stall_ok);
      cyc = 0;
      stall_ok = 1'b1;
      while (!bus.res_valid && cyc < limit) begin
         if (!bus.stall_o) stall_ok = 1'b0;
         step();
         cyc++;
      end
   endtask

   task automatic count_valids(input int n, output int hits);
      hits = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (bus.res_valid) hits++;
      end
   endtask

   task automatic run_one(input string tag, input bit lane, input div_op_t op,
                          input logic [31:0] s1, input logic [31:0] s2,
                          input logic [4:0] rd, input logic [31:0] exp);
      int cyc;
      bit sok;
      step();
      if (!lane) begin
         bus.req_a = 1'b1; bus.op_a = op; bus.src1_a = s1; bus.src2_a = s2; bus.rd_a = rd;
      end else begin
         bus.req_b = 1'b1; bus.op_b = op; bus.src1_b = s1; bus.src2_b = s2; bus.rd_b = rd;
      end
      #1;
      check_eq({tag, "_stall_req"}, 32'(bus.stall_o), 32'd1);
      step();
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
      wait_valid(100, cyc, sok);
      check_eq({tag, "_latency"}, 32'(cyc), 32'd33);
      check_eq({tag, "_stall_calc"}, 32'(sok), 32'd1);
      check_eq({tag, "_data"}, bus.res_data, exp);
      check_eq({tag, "_lane"}, 32'(bus.res_lane), 32'(lane));
      check_eq({tag, "_rd"}, 32'(bus.res_rd), 32'(rd));
      step();
      check_eq({tag, "_retired"}, 32'(bus.res_valid), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cyc;
      int  hits;
      bit  sok;
      bit  stable;

      idle_inputs();
      #12;
      check_eq("rst_valid", 32'(bus.res_valid), 32'd0);
      check_eq("rst_data",  bus.res_data, 32'd0);
      check_eq("rst_rd",    32'(bus.res_rd), 32'd0);
      check_eq("rst_lane",  32'(bus.res_lane), 32'd0);
      check_eq("rst_stall", 32'(bus.stall_o), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      step();

      run_one("div_100_7",   1'b0, DIV,  32'd100,        32'd7,          5'd3,  32'd14);
      run_one("mod_m7_2_b",  1'b1, MOD,  32'hFFFF_FFF9,  32'd2,          5'd9,  32'hFFFF_FFFF);
      run_one("divu_by0",    1'b0, DIVU, 32'hFFFF_FFFF,  32'd0,          5'd4,  32'hFFFF_FFFF);
      run_one("modu_5_0",    1'b1, MODU, 32'd5,          32'd0,          5'd5,  32'd5);
      run_one("div_ovf",     1'b0, DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd6,  32'h8000_0000);
      run_one("mod_ovf",     1'b0, MOD,  32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'd0);
      run_one("div_m100_7",  1'b0, DIV,  32'hFFFF_FF9C,  32'd7,          5'd8,  32'hFFFF_FFF2);
      run_one("mod_m100_7",  1'b1, MOD,  32'hFFFF_FF9C,  32'd7,          5'd10, 32'hFFFF_FFFE);
      run_one("div_7_0",     1'b0, DIV,  32'd7,          32'd0,          5'd11, 32'hFFFF_FFFF);
      run_one("mod_m5_0",    1'b1, MOD,  32'hFFFF_FFFB,  32'd0,          5'd12, 32'hFFFF_FFFB);
      run_one("divu_big",    1'b0, DIVU, 32'hFFFF_FF9C,  32'd16,         5'd13, 32'h0FFF_FFF9);

      // Both lanes in the same cycle: A first, B from the pending slot.
      bus.req_a = 1'b1; bus.op_a = DIV; bus.src1_a = 32'd20; bus.src2_a = 32'd3; bus.rd_a = 5'd1;
      bus.req_b = 1'b1; bus.op_b = MOD; bus.src1_b = 32'd20; bus.src2_b = 32'd3; bus.rd_b = 5'd2;
      #1;
      check_eq("dual_stall_req", 32'(bus.stall_o), 32'd1);
      step();
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
      wait_valid(100, cyc, sok);
      check_eq("dual_a_latency", 32'(cyc), 32'd33);
      check_eq("dual_a_stall", 32'(sok), 32'd1);
      check_eq("dual_a_data", bus.res_data, 32'd6);
      check_eq("dual_a_lane", 32'(bus.res_lane), 32'd0);
      check_eq("dual_a_rd", 32'(bus.res_rd), 32'd1);
      check_eq("dual_a_done_stall", 32'(bus.stall_o), 32'd1);
      step();
      wait_valid(100, cyc, sok);
      check_eq("dual_b_gap", 32'(cyc + 1), 32'd34);
      check_eq("dual_b_stall", 32'(sok), 32'd1);
      check_eq("dual_b_data", bus.res_data, 32'd2);
      check_eq("dual_b_lane", 32'(bus.res_lane), 32'd1);
      check_eq("dual_b_rd", 32'(bus.res_rd), 32'd2);
      step();
      check_eq("dual_retired", 32'(bus.res_valid), 32'd0);

      // Flush in CALC with lane B pending.
      bus.req_a = 1'b1; bus.op_a = DIV; bus.src1_a = 32'd50; bus.src2_a = 32'd5; bus.rd_a = 5'd14;
      bus.req_b = 1'b1; bus.op_b = DIV; bus.src1_b = 32'd60; bus.src2_b = 32'd6; bus.rd_b = 5'd15;
      step();
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
      for (int i = 0; i < 9; i++) step();
      check_eq("flush_pre_stall", 32'(bus.stall_o), 32'd1);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      check_eq("flush_valid", 32'(bus.res_valid), 32'd0);
      check_eq("flush_stall", 32'(bus.stall_o), 32'd0);
      count_valids(60, hits);
      check_eq("flush_no_result", 32'(hits), 32'd0);

      // Downstream stall holds the result for five cycles, then it retires once.
      bus.ex_stall = 1'b1;
      bus.req_a = 1'b1; bus.op_a = DIV; bus.src1_a = 32'd100; bus.src2_a = 32'd7; bus.rd_a = 5'd16;
      step();
      bus.req_a = 1'b0;
      wait_valid(100, cyc, sok);
      check_eq("exs_latency", 32'(cyc), 32'd33);
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (!bus.res_valid || bus.res_data !== 32'd14 || bus.res_rd !== 5'd16 || !bus.stall_o)
            stable = 1'b0;
         step();
      end
      check_eq("exs_held", 32'(stable), 32'd1);
      check_eq("exs_still_valid", 32'(bus.res_valid), 32'd1);
      bus.ex_stall = 1'b0;
      #1;
      check_eq("exs_release_stall", 32'(bus.stall_o), 32'd0);
      step();
      check_eq("exs_retired", 32'(bus.res_valid), 32'd0);
      count_valids(40, hits);
      check_eq("exs_single", 32'(hits), 32'd0);

      // Reset pulse mid-CALC discards the op.
      bus.req_a = 1'b1; bus.op_a = DIV; bus.src1_a = 32'h8000_0000; bus.src2_a = 32'hFFFF_FFFF; bus.rd_a = 5'd17;
      step();
      bus.req_a = 1'b0;
      for (int i = 0; i < 10; i++) step();
      #2;
      rstn = 1'b0;
      #1;
      check_eq("rstmid_valid", 32'(bus.res_valid), 32'd0);
      check_eq("rstmid_data", bus.res_data, 32'd0);
      check_eq("rstmid_stall", 32'(bus.stall_o), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      count_valids(60, hits);
      check_eq("rstmid_no_result", 32'(hits), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter: DIV_ITER, default 32, number of radix-2 iteration cycles per operation.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  pipeline flush; discards all in-flight and pending work.
REQ-005 ex_stall  input  1  downstream stall; holds a presented result.
REQ-006 req_a / req_b  input  1 each  lane A (older) / lane B divide request.
REQ-007 op_a / op_b  input  2 each  div_op_t: DIV=0, MOD=1, DIVU=2, MODU=3.
REQ-008 src1_a, src2_a, src1_b, src2_b  input  32 each  dividend / divisor per lane.
REQ-009 rd_a / rd_b  input  5 each  destination register per lane.
REQ-010 stall_o  output  1  freezes issue/dispatch while the unit cannot accept.
REQ-011 res_valid  output  1  result presented this cycle.
REQ-012 res_data  output  32  quotient or remainder.
REQ-013 res_rd  output  5  destination of res_data.
REQ-014 res_lane  output  1  0 = lane A, 1 = lane B.

Function
REQ-015 FSM states SHALL be IDLE, CALC, DONE; one op in div_core at a time.
REQ-016 In IDLE with req_a, lane A SHALL be accepted; lane B accepted only when req_a is low.
REQ-017 If req_a and req_b are both high in IDLE, lane B's op/sources/rd SHALL be latched into a one-entry pending buffer in the same edge.
REQ-018 Accept: IDLE->CALC; div_core started with absolute values for signed ops, sign flags recorded.
REQ-019 CALC SHALL last exactly DIV_ITER cycles, then ->DONE; res_valid high in DONE only.
REQ-020 Accept at edge N SHALL give res_valid in cycle N+DIV_ITER+1 (33 cycles after accept for default).
REQ-021 DONE with ex_stall high: remain in DONE, res_* stable.
REQ-022 DONE with ex_stall low: pending valid -> start pending op, go CALC, clear pending; else -> IDLE.
REQ-023 Signed quotient sign = sign1 XOR sign2; remainder sign = sign of dividend; magnitudes from unsigned core.
REQ-024 Divisor zero: quotient = 32'hFFFFFFFF, remainder = dividend, for all ops; latency unchanged.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF SHALL yield 0x80000000; MOD yields 0.
REQ-026 stall_o SHALL be high combinationally when (IDLE and (req_a|req_b)), in CALC, in DONE with ex_stall, or in DONE with pending valid; low otherwise.
REQ-027 Requests arriving while not IDLE SHALL be ignored (stall_o guarantees they are held upstream).
REQ-028 flush SHALL, at the next edge, force IDLE, clear pending, abort div_core; res_valid low next cycle.
REQ-029 flush SHALL take priority over acceptance, completion and ex_stall in the same cycle.
REQ-030 res_data/res_rd/res_lane SHALL be registered; no combinational path from src* to res_*.

Reset
REQ-031 On rstn low: state IDLE, pending clear, res_valid 0, res_data 0, res_rd 0, res_lane 0, div_core idle; stall_o 0 absent requests.
REQ-032 Reset mid-operation SHALL discard the op with no result emitted after release.

Structure
REQ-033 div_op_t and DIV_ITER default SHALL be declared in package Public_Info.
REQ-034 Sub-module div_core: unsigned shift-subtract, ports start, dividend, divisor, busy, quotient, remainder; div_sched owns sign handling, arbitration, FSM.

Verification
REQ-035 DIV lane A 100/7 -> res_valid at accept+33, res_data 14, res_lane 0.
REQ-036 MOD lane B -7/2, req_a low -> res_data 0xFFFFFFFF (-1), res_lane 1.
REQ-037 DIVU 0xFFFFFFFF/0 -> res_data 0xFFFFFFFF; MODU 5/0 -> 5.
REQ-038 req_a DIV 20/3 and req_b MOD 20/3 same cycle -> A result 6 then B result 2 at +34 cycles after A result, stall_o high throughout.
REQ-039 flush at CALC cycle 10 with pending B -> IDLE next cycle, no res_valid, stall_o low; ex_stall held 5 cycles in DONE -> res_data stable, single retire.
REQ-040 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; rstn pulse mid-CALC -> no result after release.
